wave_period_meter: RTL



---
 rtl/wave_meas_pkg.sv | 30 +++
 rtl/hyst_cross_det.sv | 37 +++
 rtl/wave_period_meter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wave_meas_pkg.sv
// Shared definitions for the wave period meter: FSM encoding, default widths, saturating threshold math.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package wave_meas_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_MEAS = 2'd2
    } meas_state_t;

    // a + b clamped to max_v; the extra sum bit keeps the compare honest near 2^32
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

    // a - b clamped at zero
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/hyst_cross_det.sv
// Hysteresis rising-crossing detector: arms below thr_lo, fires once at or above thr_hi.
// Latency: rise is combinational on the qualified sample; armed_low updates on the next clk edge.
// Backpressure: none; only cycles with smp_vld high are evaluated.
module hyst_cross_det
    import wave_meas_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              smp_vld,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic              rise
);

    logic armed_low;

    // A crossing only counts after the signal has been seen at or below the low band edge
    assign rise = smp_vld && armed_low && (sample >= thr_hi);

    // Track the armed flag; a rise consumes it so the next rise needs a fresh dip below thr_lo
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            armed_low <= 1'b0;
        end else if (smp_vld) begin
            if (rise) begin
                armed_low <= 1'b0;
            end else if (sample <= thr_lo) begin
                armed_low <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_period_meter.sv
// Measures one waveform period (samples), vmax/vmin/vpp per run; single-shot or continuous; optional high-time via WAVE_PERIOD_METER_DUTY_EN.
// Latency: meas_valid/timeout strobe one clk after the closing (or expiring) qualified sample; results held until next meas_valid or rst.
// Backpressure: none; the sink must accept the one-cycle strobes, start is ignored while busy.
module wave_period_meter
    import wave_meas_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HYST        = 8,
    parameter int TIMEOUT_SMP = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] thresh,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic              timeout
`ifdef WAVE_PERIOD_METER_DUTY_EN
    ,
    output logic [CNT_W-1:0]  high_time
`endif
);

    localparam logic [31:0]      DMAX   = 32'((64'd1 << DATA_W) - 64'd1);
    localparam logic [31:0]      HYST_V = 32'(HYST);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_SMP);

    meas_state_t       state;
    logic [DATA_W-1:0] thr_hi;
    logic [DATA_W-1:0] thr_lo;
    logic              cont_r;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cur_min;
    logic [DATA_W-1:0] cur_max;

    logic              acc_start;
    logic              eval;
    logic              rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] min_nxt;
    logic [DATA_W-1:0] max_nxt;

`ifdef WAVE_PERIOD_METER_DUTY_EN
    logic [DATA_W-1:0] thr_r;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  high_nxt;
`endif

    assign busy      = (state != ST_IDLE);
    assign acc_start = start && (state == ST_IDLE);
    assign eval      = sample_en && (state != ST_IDLE);

    // Running counter and extremes including the current sample
    assign cnt_inc = cnt + 1'b1;
    assign min_nxt = (sample_in < cur_min) ? sample_in : cur_min;
    assign max_nxt = (sample_in > cur_max) ? sample_in : cur_max;

`ifdef WAVE_PERIOD_METER_DUTY_EN
    // High-time count including the current sample
    assign high_nxt = (sample_in >= thr_r) ? (high_cnt + 1'b1) : high_cnt;
`endif

    hyst_cross_det #(
        .DATA_W (DATA_W)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_start),
        .smp_vld (eval),
        .sample  (sample_in),
        .thr_hi  (thr_hi),
        .thr_lo  (thr_lo),
        .rise    (rise)
    );

    // Run control: arm on start, sync to the first rise, measure to the next rise, abort on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            thr_hi     <= '0;
            thr_lo     <= '0;
            cont_r     <= 1'b0;
            cnt        <= '0;
            cur_min    <= '0;
            cur_max    <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period     <= '0;
            vmax       <= '0;
            vmin       <= '0;
            vpp        <= '0;
`ifdef WAVE_PERIOD_METER_DUTY_EN
            thr_r      <= '0;
            high_cnt   <= '0;
            high_time  <= '0;
`endif
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        thr_hi <= DATA_W'(sat_add(32'(thresh), HYST_V, DMAX));
                        thr_lo <= DATA_W'(sat_sub(32'(thresh), HYST_V));
                        cont_r <= cont;
                        cnt    <= '0;
`ifdef WAVE_PERIOD_METER_DUTY_EN
                        thr_r  <= thresh;
`endif
                        state  <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (sample_en) begin
                        if (rise) begin
                            // Opening crossing: this sample starts the period but is not counted in it
                            cur_min  <= sample_in;
                            cur_max  <= sample_in;
                            cnt      <= '0;
`ifdef WAVE_PERIOD_METER_DUTY_EN
                            high_cnt <= '0;
`endif
                            state    <= ST_MEAS;
                        end else if (cnt_inc == TMO) begin
                            timeout <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_MEAS: begin
                    if (sample_en) begin
                        if (rise) begin
                            // Closing crossing: the closing sample is part of the finished period
                            period     <= cnt_inc;
                            vmax       <= max_nxt;
                            vmin       <= min_nxt;
                            vpp        <= max_nxt - min_nxt;
                            meas_valid <= 1'b1;
`ifdef WAVE_PERIOD_METER_DUTY_EN
                            high_time  <= high_nxt;
`endif
                            if (cont_r) begin
                                // Same sample opens the next period
                                cur_min  <= sample_in;
                                cur_max  <= sample_in;
                                cnt      <= '0;
`ifdef WAVE_PERIOD_METER_DUTY_EN
                                high_cnt <= '0;
`endif
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else if (cnt_inc == TMO) begin
                            timeout <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            cnt      <= cnt_inc;
                            cur_min  <= min_nxt;
                            cur_max  <= max_nxt;
`ifdef WAVE_PERIOD_METER_DUTY_EN
                            high_cnt <= high_nxt;
`endif
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
